// File: rtl/kyber_pkg.sv
// Shared constants, FSM state type and lane-pair offset table for the
// polynomial byte encoder.
package kyber_pkg;

  localparam int KYBER_N         = 256;
  localparam int COEFF_W         = 12;
  localparam int COEFFS_PER_WORD = 8;
  localparam int WORDS_PER_POLY  = 32;
  localparam int BYTES_PER_POLY  = 384;
  localparam int WORD_W          = COEFF_W * COEFFS_PER_WORD;
  localparam int PAIR_W          = 2 * COEFF_W;
  localparam int PASSES          = KYBER_N / (2 * WORDS_PER_POLY);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } enc_state_t;

  // Passes visit lane pairs out of bit order so coefficients come out 0..255.
  function automatic logic [6:0] pair_offset(input logic [1:0] pass);
    case (pass)
      2'd0:    return 7'd0;
      2'd1:    return 7'd48;
      2'd2:    return 7'd24;
      2'd3:    return 7'd72;
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/pair_serializer.sv
// Holds one 24-bit coefficient pair and presents it as three bytes under
// valid/ready; pair_done flags the handshake of the third byte.
module pair_serializer
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [PAIR_W-1:0] pair,
  input  logic              last,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  output logic              byte_last,
  input  logic              byte_ready,
  output logic              pair_done
);

  logic [PAIR_W-1:0] pair_r;
  logic [1:0]        bsel;
  logic              last_r;

  assign pair_done = byte_valid & byte_ready & (bsel == 2'd2);

  // Byte order a[7:0], {b[3:0],a[11:8]}, b[11:4] is a plain byte split of {b,a}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_r     <= '0;
      bsel       <= 2'd0;
      last_r     <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
    end else if (load) begin
      pair_r     <= pair;
      last_r     <= last;
      bsel       <= 2'd0;
      byte_out   <= pair[7:0];
      byte_valid <= 1'b1;
      byte_last  <= 1'b0;
    end else if (byte_valid && byte_ready) begin
      case (bsel)
        2'd0: begin
          byte_out  <= pair_r[15:8];
          byte_last <= 1'b0;
          bsel      <= 2'd1;
        end
        2'd1: begin
          byte_out  <= pair_r[23:16];
          byte_last <= last_r;
          bsel      <= 2'd2;
        end
        default: begin
          byte_valid <= 1'b0;
          byte_last  <= 1'b0;
          bsel       <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/poly_byte_encoder.sv
// Streams one packed 256-coefficient polynomial from RAM as the 384-byte
// 12-bit byte encoding, reading each word once per quarter pass.
module poly_byte_encoder
  import kyber_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ram_r_start_offset,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  input  logic [WORD_W-1:0] rdata,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic              busy,
  output logic              finish
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);
  localparam logic [4:0] LAST_WORD = 5'(WORDS_PER_POLY - 1);

  enc_state_t        state;
  logic [1:0]        pass;
  logic [4:0]        word;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] base;
  logic [6:0]        pw_next;
  logic              last_pair;
  logic              load;
  logic [PAIR_W-1:0] pair;
  logic              pair_done;

  assign pw_next   = {pass, word} + 7'd1;
  assign last_pair = (pass == LAST_PASS) && (word == LAST_WORD);
  assign load      = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
  assign pair      = rdata[pair_offset(pass) +: PAIR_W];

  // Sequencer: one read per word per pass, then wait for the pair to drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pass     <= 2'd0;
      word     <= 5'd0;
      wait_cnt <= 2'd0;
      base     <= '0;
      ren      <= 1'b0;
      raddr    <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          finish <= 1'b0;
          if (start) begin
            base  <= ram_r_start_offset;
            pass  <= 2'd0;
            word  <= 5'd0;
            ren   <= 1'b1;
            raddr <= ram_r_start_offset;
            busy  <= 1'b1;
            state <= ST_RD;
          end
        end
        ST_RD: begin
          ren      <= 1'b0;
          wait_cnt <= 2'd0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= ST_EMIT;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_EMIT: begin
          if (pair_done) begin
            if (last_pair) begin
              finish <= 1'b1;
              state  <= ST_DONE;
            end else begin
              {pass, word} <= pw_next;
              ren          <= 1'b1;
              raddr        <= base + ADDR_W'(pw_next[4:0]);
              state        <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          finish <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          ren   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  pair_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .pair       (pair),
    .last       (last_pair),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .pair_done  (pair_done)
  );

endmodule

// File: tb/tb_poly_byte_encoder.sv
// Scoreboard bench: packs random byte vectors into RAM the way the sampler
// does and checks the encoder reproduces them (1-cycle and 3-cycle RAM).
module tb_poly_byte_encoder;
  import kyber_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  ram_r_start_offset = 9'h000;
  logic        ren;
  logic [8:0]  raddr;
  logic [95:0] rdata = '0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        byte_last;
  logic        busy;
  logic        finish;

  logic        start_b = 1'b0;
  logic [8:0]  off_b = 9'h040;
  logic        ren_b;
  logic [8:0]  raddr_b;
  logic [95:0] rdata_b = '0;
  logic [95:0] d1_b = '0;
  logic [95:0] d2_b = '0;
  logic [7:0]  bo_b;
  logic        bv_b;
  logic        ready_b = 1'b1;
  logic        bl_b;
  logic        busy_b;
  logic        fin_b;

  logic [95:0] mem [512];
  logic [7:0]  vec [BYTES_PER_POLY];
  logic [7:0]  got [BYTES_PER_POLY];
  logic [7:0]  q [$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          acc_cnt = 0;
  int          rd_cnt = 0;
  logic [8:0]  cur_off = 9'h000;
  bit          rdy_rand = 1'b0;
  bit          stalled = 1'b0;
  bit          fin_due = 1'b0;
  logic [7:0]  stall_byte = 8'h00;
  logic        stall_last = 1'b0;

  always #5 clk = ~clk;

  poly_byte_encoder #(.ADDR_W(9), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .ram_r_start_offset(ram_r_start_offset),
    .ren(ren), .raddr(raddr), .rdata(rdata), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last),
    .busy(busy), .finish(finish));

  poly_byte_encoder #(.ADDR_W(9), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start_b), .ram_r_start_offset(off_b),
    .ren(ren_b), .raddr(raddr_b), .rdata(rdata_b), .byte_out(bo_b),
    .byte_valid(bv_b), .byte_ready(ready_b), .byte_last(bl_b),
    .busy(busy_b), .finish(fin_b));

  always @(posedge clk) begin
    if (ren) rdata <= mem[raddr];
    d1_b    <= ren_b ? mem[raddr_b] : 96'h0;
    d2_b    <= d1_b;
    rdata_b <= d2_b;
  end

  always @(posedge clk) begin
    #1 byte_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: address model, handshake scoreboard, stall stability, finish timing.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
      fin_due = 1'b0;
    end else begin
      if (ren) begin
        chk("raddr", 32'(raddr), 32'(9'(cur_off + 9'(rd_cnt % 32))));
        rd_cnt++;
      end
      if (stalled) begin
        chk("stall_valid", 32'(byte_valid), 32'd1);
        chk("stall_byte", {23'd0, byte_last, byte_out}, {23'd0, stall_last, stall_byte});
      end
      if (fin_due || finish) chk("finish", 32'(finish), 32'(fin_due));
      fin_due = 1'b0;
      if (byte_valid && byte_ready) begin
        if (q.size() == 0) begin
          chk("extra_byte", 32'(acc_cnt), 32'(BYTES_PER_POLY));
        end else begin
          chk("byte", 32'(byte_out), 32'(q.pop_front()));
          chk("byte_last", 32'(byte_last), 32'(acc_cnt == BYTES_PER_POLY - 1));
          if (acc_cnt < BYTES_PER_POLY) got[acc_cnt] = byte_out;
          if (acc_cnt == BYTES_PER_POLY - 1) fin_due = 1'b1;
        end
        acc_cnt++;
      end
      stalled    = byte_valid && !byte_ready;
      stall_byte = byte_out;
      stall_last = byte_last;
    end
  end

  // Sampler-style packing: bytes -> 12-bit coeffs -> interleaved RAM lanes.
  task automatic load_poly(input logic [8:0] off, input bit fix);
    logic [11:0] c [KYBER_N];
    for (int i = 0; i < BYTES_PER_POLY; i++) vec[i] = 8'($urandom);
    if (fix) begin
      vec[0] = 8'h23; vec[1] = 8'hC1; vec[2] = 8'hAB;
    end
    for (int j = 0; j < KYBER_N / 2; j++) begin
      c[2*j]   = {vec[3*j+1][3:0], vec[3*j]};
      c[2*j+1] = {vec[3*j+2], vec[3*j+1][7:4]};
    end
    for (int k = 0; k < 32; k++)
      mem[9'(off + 9'(k))] = {c[193+2*k], c[192+2*k], c[65+2*k], c[64+2*k],
                              c[129+2*k], c[128+2*k], c[1+2*k], c[2*k]};
  endtask

  task automatic kick(input logic [8:0] off);
    cur_off = off;
    acc_cnt = 0;
    rd_cnt  = 0;
    for (int i = 0; i < BYTES_PER_POLY; i++) q.push_back(vec[i]);
    @(posedge clk); #1;
    start = 1'b1;
    ram_r_start_offset = off;
    @(posedge clk); #1;
    start = 1'b0;
    ram_r_start_offset = 9'($urandom);
    chk("ren_first", 32'(ren), 32'd1);
    chk("raddr_first", 32'(raddr), 32'(off));
  endtask

  task automatic run_poly(input logic [8:0] off, input bit rnd, input bit mid);
    int n;
    rdy_rand = rnd;
    kick(off);
    n = 0;
    while (!byte_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd2);
    if (mid) begin
      repeat (30) @(posedge clk);
      #1 start = 1'b1;
      ram_r_start_offset = 9'h155;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    while (!finish && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("finish_seen", 32'(finish), 32'd1);
    @(posedge clk); #1;
    chk("busy_after", 32'(busy), 32'd0);
    chk("finish_pulse", 32'(finish), 32'd0);
    chk("bytes", 32'(acc_cnt), 32'(BYTES_PER_POLY));
    chk("reads", 32'(rd_cnt), 32'd128);
    chk("queue_empty", 32'(q.size()), 32'd0);
    rdy_rand = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ren"}, 32'(ren), 32'd0);
    chk({tag, "_raddr"}, 32'(raddr), 32'd0);
    chk({tag, "_byte_out"}, 32'(byte_out), 32'd0);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, "_byte_last"}, 32'(byte_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_finish"}, 32'(finish), 32'd0);
  endtask

  initial begin
    int n;
    int idx;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst = 1'b0;

    // word 0 lanes 0/1 = 0x123/0xABC at offset 0
    load_poly(9'h000, 1'b1);
    run_poly(9'h000, 1'b0, 1'b0);
    chk("t1_b0", 32'(got[0]), 32'h23);
    chk("t1_b1", 32'(got[1]), 32'hC1);
    chk("t1_b2", 32'(got[2]), 32'hAB);

    load_poly(9'h040, 1'b0);
    run_poly(9'h040, 1'b0, 1'b0);
    load_poly(9'h040, 1'b0);
    run_poly(9'h040, 1'b1, 1'b0);
    load_poly(9'h1F0, 1'b0);
    run_poly(9'h1F0, 1'b1, 1'b0);
    load_poly(9'h080, 1'b0);
    run_poly(9'h080, 1'b0, 1'b1);

    // abort mid-stream with reset, then a clean run
    load_poly(9'h0C0, 1'b0);
    kick(9'h0C0);
    for (n = 0; n < 5000 && acc_cnt < 100; n++) @(posedge clk);
    chk("reached_byte100", 32'(acc_cnt >= 100), 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("abort");
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("abort_idle", {30'd0, busy, finish}, 32'd0);
    load_poly(9'h0C0, 1'b0);
    run_poly(9'h0C0, 1'b1, 1'b0);

    // 3-cycle RAM latency instance
    load_poly(9'h040, 1'b0);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (!bv_b && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat3", 32'(n), 32'd4);
    idx = 0;
    for (int c = 0; c < 5000 && !fin_b; c++) begin
      @(negedge clk);
      if (bv_b && idx < BYTES_PER_POLY) begin
        chk("lat3_byte", 32'(bo_b), 32'(vec[idx]));
        chk("lat3_last", 32'(bl_b), 32'(idx == BYTES_PER_POLY - 1));
        idx++;
      end
    end
    chk("lat3_finish", 32'(fin_b), 32'd1);
    chk("lat3_count", 32'(idx), 32'(BYTES_PER_POLY));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
